// File: rtl/shared_delay_arbiter_pkg.sv
// Shared definitions for the shared delay arbiter: FSM state encoding,
// parameter limits and the index-width helper used for cur_idx.
package shared_delay_arbiter_pkg;

  // Supported configuration range for requester count and counter width.
  localparam int N_MIN = 2;
  localparam int N_MAX = 8;
  localparam int W_MIN = 1;
  localparam int W_MAX = 32;

  // Transfer phases: arbitrate, load the counter, count strobes, signal completion.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Number of bits needed to index n requesters (ceil(log2(n))).
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_delay_arbiter_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... (mod N) and
// returns the first requester found, so the previous winner ranks last.
module rr_pick
  import shared_delay_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  // Walk the search order from farthest to nearest so the nearest hit wins.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    winner_o = '0;
    valid_o  = |req_i;
    cand     = 0;
    cand_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (req_i[cand_idx]) begin
        winner_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/shared_delay_arbiter.sv
// Shared delay arbiter: N requesters share one programmable down-counter.
// A round-robin winner is loaded with its delay, the counter decrements on
// cnt_en strobes and the owner receives a one-cycle done pulse.
// Optional feature macro: SHARED_DELAY_ARBITER_ABORT_EN -- when defined, an
// owner dropping its request during LOAD/RUN cancels the transfer (no done).
module shared_delay_arbiter
  import shared_delay_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 16,
  localparam int IW = log2_ceil(N)
) (
  input  logic            CLK50MHZ,
  input  logic            rst,
  input  logic            cnt_en,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  delay,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic [IW-1:0]   cur_idx
);

  // Reject unsupported configurations at elaboration.
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("shared_delay_arbiter: N out of range");
  end
  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("shared_delay_arbiter: W out of range");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;

  logic [W-1:0]  delay_slot [N];
  logic [N-1:0]  owner_onehot;
  logic [W-1:0]  owner_delay;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          owner_drop;

  // Unpack the delay bus and decode the owner index into a one-hot vector.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign delay_slot[gi]   = delay[gi*W +: W];
      assign owner_onehot[gi] = (cur_idx_q == IW'(gi));
    end
  endgenerate

  // Select the owner's delay through the one-hot decode (safe for non power-of-2 N).
  always_comb begin
    owner_delay = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_onehot[i]) begin
        owner_delay = owner_delay | delay_slot[i];
      end
    end
  end

`ifdef SHARED_DELAY_ARBITER_ABORT_EN
  // Owner withdrawing its request cancels the transfer in progress.
  assign owner_drop = ~|(req & owner_onehot);
`else
  // Once granted the timer always runs to completion.
  assign owner_drop = 1'b0;
`endif

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state, counter and output decisions for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_idx_d = cur_idx_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    done_d    = '0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          cur_idx_d = pick_idx;
          ptr_d     = pick_idx;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (owner_drop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else begin
          // Delay is captured only here; later changes on the bus are ignored.
          cnt_d   = owner_delay;
          grant_d = owner_onehot;
          if (owner_delay == '0) begin
            state_d = S_DONE;
            done_d  = owner_onehot;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (owner_drop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else if (cnt_en && (cnt_q != '0)) begin
          cnt_d = cnt_q - W'(1);
          if (cnt_q == W'(1)) begin
            state_d = S_DONE;
            done_d  = owner_onehot;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any transfer.
  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cur_idx_q <= '0;
      ptr_q     <= IW'(N - 1);
      grant_q   <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_idx_q <= cur_idx_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);
  assign cur_idx = cur_idx_q;

endmodule
